pipelined_cla_addsub: RTL
=========================

PIPELINED_CLA_ADDSUB -- requirements
Module: pipelined_cla_addsub

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter STAGES, default 2, number of pipeline stages; legal values 1, 2, 4, with WIDTH/STAGES a multiple of 4.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand set on in1/in2/op/c_in is valid.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 in1  input  WIDTH  first operand.
REQ-008 in2  input  WIDTH  second operand.
REQ-009 op  input  1  0 = add, 1 = subtract (in1 - in2).
REQ-010 c_in  input  1  carry-in for add; for subtract, 1 = normal subtract, 0 = subtract-with-borrow.
REQ-011 out_valid  output  1  result fields valid.
REQ-012 out_ready  input  1  consumer accepts result this cycle.
REQ-013 sum  output  WIDTH  result.
REQ-014 c_out  output  1  carry out of bit WIDTH-1.
REQ-015 ovf  output  1  two's-complement signed overflow.
REQ-016 zero  output  1  sum == 0.
REQ-017 neg  output  1  sum[WIDTH-1].

Function
REQ-018 Effective operand b = op ? ~in2 : in2; effective carry-in = c_in; result = in1 + b + c_in modulo 2^WIDTH.
REQ-019 Operand split into STAGES slices of WIDTH/STAGES bits, LSB slice first; slice k SHALL be summed in stage k using 4-bit carry-lookahead groups with group propagate/generate combined by a lookahead unit, no ripple between groups.
REQ-020 Carry out of slice k SHALL be registered and used as carry-in to slice k+1 in stage k+1; not-yet-summed upper operand bits and completed lower sum bits SHALL travel with the stage registers.
REQ-021 c_out = carry out of final slice; ovf = carry into MSB XOR carry out of MSB.
REQ-022 zero and neg SHALL be computed from the final registered sum, same cycle as out_valid.
REQ-023 Latency: operands accepted at edge N appear on outputs after edge N+STAGES-1 when no stall (i.e. valid at output STAGES cycles after in_valid&&in_ready asserted), one result per cycle throughput.
REQ-024 Each stage holds a valid bit; stage advances when its successor is empty or advancing; final stage advances when out_ready=1.
REQ-025 in_ready = !stage0_valid || stage0 advancing; combinational dependence on out_ready permitted.
REQ-026 While out_valid=1 and out_ready=0, sum/c_out/ovf/zero/neg and out_valid SHALL hold stable.
REQ-027 No result dropped or duplicated; results emerge in acceptance order.
REQ-028 Pipeline full (all stage valids set) with out_ready=0: in_ready=0.
REQ-029 Simultaneous accept and emit when full with out_ready=1: in_ready=1, occupancy unchanged.
REQ-030 Bubbles (in_valid=0) SHALL propagate as invalid stages and be collapsed by downstream stalls.
REQ-031 Inputs ignored when in_valid=0 or in_ready=0.

Reset
REQ-032 On rst=1 at a clock edge: all stage valid bits cleared; out_valid=0; sum=0, c_out=0, ovf=0, zero=0, neg=0.
REQ-033 During rst=1, in_ready=0.
REQ-034 rst asserted mid-operation discards all in-flight operations; no result from them SHALL appear after rst deasserts.
REQ-035 First operand accepted on the first edge with rst=0 and in_valid=1.

Verification
REQ-036 WIDTH=32, STAGES=2: in1=0xFFFFFFFF, in2=0x00000001, op=0, c_in=0 -> 2 cycles later sum=0x00000000, c_out=1, zero=1, ovf=0, neg=0.
REQ-037 WIDTH=32, STAGES=2: in1=0x7FFFFFFF, in2=0x00000001, op=0, c_in=0 -> sum=0x80000000, ovf=1, neg=1, c_out=0.
REQ-038 WIDTH=32: in1=5, in2=7, op=1, c_in=1 -> sum=0xFFFFFFFE, c_out=0, neg=1, ovf=0; in1=7, in2=5 -> sum=2, c_out=1.
REQ-039 Back-to-back stream of 8 operand pairs with out_ready held 0 for cycles 3-6 -> in_ready drops once STAGES entries held, all 8 results emerge in order, outputs stable while stalled.
REQ-040 Assert rst for one cycle with 2 operations in flight -> out_valid=0 next cycle, no stale result later; next accepted op completes with correct value.
REQ-041 Random constrained run with WIDTH=64, STAGES=4 and WIDTH=16, STAGES=1, random in_valid/out_ready -> every result matches reference model of REQ-018/021.

Source files
------------

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor with a valid/ready handshake.
// The operand is split into STAGES slices, LSB slice first. Each stage sums
// one slice with 4-bit lookahead groups and registers that slice's carry out
// for the next stage. Upper operand bits and finished lower sum bits travel
// along with the stage registers.
module pipelined_cla_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             op,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int SW   = WIDTH / STAGES;
    localparam int NG   = SW / 4;
    localparam int LW   = (NG > 4) ? NG : 4;
    localparam int LAST = STAGES - 1;

    // Flat lookahead carries: c[j] = OR_i (g[i] & p[i+1..j-1]) | (p[0..j-1] & ci).
    // Only the low n positions are meaningful; no carry ripples between positions.
    function automatic logic [LW:0] lookahead(input logic [LW-1:0] p, input logic [LW-1:0] g,
                                              input logic ci, input int n);
        logic [LW:0] c;
        logic        term;
        c    = '0;
        c[0] = ci;
        for (int j = 1; j <= LW; j++) begin
            if (j <= n) begin
                term = ci;
                for (int m = 0; m < LW; m++)
                    if (m < j) term = term & p[m];
                c[j] = term;
                for (int i = 0; i < LW; i++) begin
                    if (i < j) begin
                        term = g[i];
                        for (int m = 0; m < LW; m++)
                            if (m > i && m < j) term = term & p[m];
                        c[j] = c[j] | term;
                    end
                end
            end
        end
        return c;
    endfunction

    // Carry into every bit of a slice plus the slice carry out (bit SW).
    // Group P/G come from 4-bit lookahead; group carries from a second lookahead level.
    function automatic logic [SW:0] cla_carries(input logic [SW-1:0] a, input logic [SW-1:0] b,
                                                input logic ci);
        logic [SW-1:0] p, g;
        logic [LW-1:0] gp, gg, tp, tg;
        logic [LW:0]   gc, bc;
        logic [SW:0]   c;
        p  = a ^ b;
        g  = a & b;
        gp = '0;
        gg = '0;
        c  = '0;
        for (int j = 0; j < NG; j++) begin
            tp      = '0;
            tg      = '0;
            tp[3:0] = p[4*j +: 4];
            tg[3:0] = g[4*j +: 4];
            bc      = lookahead(tp, tg, 1'b0, 4);
            gp[j]   = &tp[3:0];
            gg[j]   = bc[4];
        end
        gc = lookahead(gp, gg, ci, NG);
        for (int j = 0; j < NG; j++) begin
            tp          = '0;
            tg          = '0;
            tp[3:0]     = p[4*j +: 4];
            tg[3:0]     = g[4*j +: 4];
            bc          = lookahead(tp, tg, gc[j], 4);
            c[4*j +: 4] = bc[3:0];
        end
        c[SW] = gc[NG];
        return c;
    endfunction

    logic [WIDTH-1:0] a_q   [0:STAGES-1];
    logic [WIDTH-1:0] b_q   [0:STAGES-1];
    logic [WIDTH-1:0] s_q   [0:STAGES-1];
    logic             c_q   [0:STAGES-1];
    logic [STAGES-1:0] v_q;
    logic             ovf_q;

    logic [WIDTH-1:0] src_a [0:STAGES-1];
    logic [WIDTH-1:0] src_b [0:STAGES-1];
    logic [WIDTH-1:0] src_s [0:STAGES-1];
    logic             src_c [0:STAGES-1];
    logic             src_v [0:STAGES-1];
    logic [WIDTH-1:0] s_d   [0:STAGES-1];
    logic             c_d   [0:STAGES-1];
    logic [SW:0]      car   [0:STAGES-1];
    logic             ovf_d;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] ld;

    // Route each stage's inputs: stage 0 from the ports, later stages from the previous register.
    always_comb begin
        src_a[0] = in1;
        src_b[0] = op ? ~in2 : in2;
        src_c[0] = c_in;
        src_s[0] = '0;
        src_v[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            src_a[k] = a_q[k-1];
            src_b[k] = b_q[k-1];
            src_c[k] = c_q[k-1];
            src_s[k] = s_q[k-1];
            src_v[k] = v_q[k-1];
        end
    end

    // Sum slice k in stage k; overflow is taken from the carries around the MSB.
    always_comb begin
        ovf_d = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            car[k]              = cla_carries(src_a[k][k*SW +: SW], src_b[k][k*SW +: SW], src_c[k]);
            s_d[k]              = src_s[k];
            s_d[k][k*SW +: SW]  = src_a[k][k*SW +: SW] ^ src_b[k][k*SW +: SW] ^ car[k][SW-1:0];
            c_d[k]              = car[k][SW];
        end
        ovf_d = car[LAST][SW] ^ car[LAST][SW-1];
    end

    // Stage k advances when everything downstream can make room; an empty stage
    // anywhere downstream lets the stages above it collapse into it.
    always_comb begin
        logic room;
        room = out_ready;
        adv  = '0;
        ld   = '0;
        for (int k = LAST; k >= 0; k--) begin
            adv[k] = v_q[k] && room;
            ld[k]  = !v_q[k] || adv[k];
            room   = room || !v_q[k];
        end
        in_ready = !rst && ld[0];
    end

    // Stage registers; data only loads with a valid entry so stalled outputs hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q   <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ld[k]) begin
                    v_q[k] <= src_v[k];
                    if (src_v[k]) begin
                        a_q[k] <= src_a[k];
                        b_q[k] <= src_b[k];
                        s_q[k] <= s_d[k];
                        c_q[k] <= c_d[k];
                    end
                end
            end
            if (ld[LAST] && src_v[LAST]) ovf_q <= ovf_d;
        end
    end

    assign out_valid = v_q[LAST];
    assign sum       = s_q[LAST];
    assign c_out     = c_q[LAST];
    assign ovf       = ovf_q;
    assign zero      = v_q[LAST] && (s_q[LAST] == '0);
    assign neg       = s_q[LAST][WIDTH-1];

endmodule
